// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
//   det_mode_t      : detection mode held in the config register
//   PAT_W_MIN/MAX   : legal bounds for the pattern length
//   fill_width()    : bits needed to hold a fill count of 0..pat_w
package seq_det_pkg;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } det_mode_t;

  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 32;

  function automatic int unsigned fill_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Stream/config/status bundle for seq_detector_param.
//   din, din_valid     : qualified serial input bit
//   cfg_load, pattern, overlap : run-time configuration load
//   cnt_clr            : clear the match counter
//   out, match_cnt     : registered match pulse and saturating match count
// master = the block driving the stream, slave = the detector.
interface seq_detector_param_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);

  logic             din;
  logic             din_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] pattern;
  logic             overlap;
  logic             cnt_clr;
  logic             out;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output din, din_valid, cfg_load, pattern, overlap, cnt_clr,
    input  out, match_cnt
  );

  modport slave (
    input  din, din_valid, cfg_load, pattern, overlap, cnt_clr,
    output out, match_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock and synchronous active-high reset
//   clr      : clear to zero
//   inc      : increment by one, holding at all-ones
//   value    : registered count
// clr and inc on the same edge give 1: the clear is applied first.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end
    if (inc && (value_d != {WIDTH{1'b1}})) begin
      value_d = value_d + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of seq_detector_param_if (stream in, config in,
//              match pulse and saturating match count out)
// The pattern MSB is the first bit received. In non-overlap mode a match
// restarts the fill count so the next match needs PAT_W fresh bits; in
// overlap mode fill stays full and matches may share bits.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  seq_detector_param_if.slave  bus
);

  localparam int unsigned FillW = fill_width(PAT_W);

  if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W must be within 2..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W must be at least 1");
  end

  logic [PAT_W-1:0] sr_q, sr_d, sr_shift;
  logic [PAT_W-1:0] pat_q;
  det_mode_t        mode_q;
  logic [FillW-1:0] fill_q, fill_d, fill_inc;
  logic             out_q;
  logic             match;

  always_comb begin
    sr_shift = {sr_q[PAT_W-2:0], bus.din};
    fill_inc = (fill_q == FillW'(PAT_W)) ? fill_q : fill_q + FillW'(1);
    sr_d     = sr_q;
    fill_d   = fill_q;
    match    = 1'b0;
    if (bus.cfg_load) begin
      // A load abandons the partial sequence and discards any same-edge bit.
      sr_d   = '0;
      fill_d = '0;
    end else if (bus.din_valid) begin
      sr_d   = sr_shift;
      fill_d = fill_inc;
      if ((fill_inc == FillW'(PAT_W)) && (sr_shift == pat_q)) begin
        match = 1'b1;
        if (mode_q == MODE_NONOVL) begin
          fill_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      fill_q <= '0;
      pat_q  <= '0;
      mode_q <= MODE_NONOVL;
      out_q  <= 1'b0;
    end else begin
      if (bus.cfg_load) begin
        pat_q  <= bus.pattern;
        mode_q <= bus.overlap ? MODE_OVL : MODE_NONOVL;
      end
      sr_q   <= sr_d;
      fill_q <= fill_d;
      out_q  <= match;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.cnt_clr),
    .inc   (match),
    .value (bus.match_cnt)
  );

  assign bus.out = out_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param. Three instances: A (PAT_W=4, CNT_W=8),
// B (PAT_W=4, CNT_W=2) and C (PAT_W=8, CNT_W=8). Every cycle the expected
// out/match_cnt of all three are pushed to a scoreboard queue and popped
// after the next rising edge.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) if_a ();
  seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) if_b ();
  seq_detector_param_if #(.PAT_W(8), .CNT_W(8)) if_c ();

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  seq_detector_param #(.PAT_W(4), .CNT_W(2)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  seq_detector_param #(.PAT_W(8), .CNT_W(8)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Reference model state, one slot per instance.
  int          pw[3]   = '{4, 4, 8};
  int          cmax[3] = '{255, 3, 255};
  logic [31:0] m_sr[3];
  logic [31:0] m_pat[3];
  int          m_fill[3];
  int          m_cnt[3];
  bit          m_ovl[3];
  int          m_pulses[3] = '{0, 0, 0};
  int          pulses[3]   = '{0, 0, 0};

  typedef struct packed {
    logic [2:0] o;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
  } exp_t;

  exp_t sbq[$];

  function automatic void model_edge(input int i, input bit r, input bit ld,
                                     input logic [31:0] pat, input bit ovl, input bit v,
                                     input bit d, input bit clr, output bit o);
    logic [31:0] mask;
    mask = (32'd1 << pw[i]) - 32'd1;
    o = 1'b0;
    if (r) begin
      m_sr[i] = '0; m_pat[i] = '0; m_fill[i] = 0; m_cnt[i] = 0; m_ovl[i] = 1'b0;
      return;
    end
    if (clr) m_cnt[i] = 0;
    if (ld) begin
      m_pat[i] = pat & mask; m_ovl[i] = ovl; m_sr[i] = '0; m_fill[i] = 0;
    end else if (v) begin
      m_sr[i] = ((m_sr[i] << 1) | {31'd0, d}) & mask;
      if (m_fill[i] < pw[i]) m_fill[i] = m_fill[i] + 1;
      if ((m_fill[i] == pw[i]) && (m_sr[i] == m_pat[i])) begin
        o = 1'b1;
        m_pulses[i] = m_pulses[i] + 1;
        if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
        if (!m_ovl[i]) m_fill[i] = 0;
      end
    end
  endfunction

  // Drive one cycle: instance k gets the given inputs, the others idle.
  task automatic step(input int k, input bit v, input bit d, input bit ld,
                      input logic [31:0] pat, input bit ovl, input bit clr);
    exp_t e;
    bit   o;
    if_a.din = d; if_a.din_valid = v && (k == 0); if_a.cfg_load = ld && (k == 0);
    if_a.pattern = pat[3:0]; if_a.overlap = ovl; if_a.cnt_clr = clr && (k == 0);
    if_b.din = d; if_b.din_valid = v && (k == 1); if_b.cfg_load = ld && (k == 1);
    if_b.pattern = pat[3:0]; if_b.overlap = ovl; if_b.cnt_clr = clr && (k == 1);
    if_c.din = d; if_c.din_valid = v && (k == 2); if_c.cfg_load = ld && (k == 2);
    if_c.pattern = pat[7:0]; if_c.overlap = ovl; if_c.cnt_clr = clr && (k == 2);
    for (int i = 0; i < 3; i++) begin
      model_edge(i, rst, ld && (k == i), pat, ovl, v && (k == i), d, clr && (k == i), o);
      e.o[i] = o;
    end
    e.c0 = 8'(m_cnt[0]);
    e.c1 = 8'(m_cnt[1]);
    e.c2 = 8'(m_cnt[2]);
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(-1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // One idle cycle, then wait until the scoreboard has consumed it.
  task automatic settle();
    idle();
    #2;
  endtask

  task automatic load(input int k, input logic [31:0] pat, input bit ovl, input bit clr);
    step(k, 1'b0, 1'b0, 1'b1, pat, ovl, clr);
  endtask

  task automatic send_bits(input int k, input logic [31:0] bits, input int n);
    for (int j = n - 1; j >= 0; j--) begin
      step(k, 1'b1, bits[j], 1'b0, 32'd0, 1'b0, 1'b0);
    end
  endtask

  // Scoreboard: pop after every rising edge that has a pending expectation.
  always @(posedge clk) begin
    exp_t e;
    #2;
    cycle++;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      pulses[0] += int'(if_a.out === 1'b1);
      pulses[1] += int'(if_b.out === 1'b1);
      pulses[2] += int'(if_c.out === 1'b1);
      checks += 3;
      if (if_a.out !== e.o[0] || if_a.match_cnt !== e.c0) begin
        failures++;
        $display("FAIL sb_a cycle=%0d out=%b cnt=%0d expected out=%b cnt=%0d",
                 cycle, if_a.out, if_a.match_cnt, e.o[0], e.c0);
      end
      if (if_b.out !== e.o[1] || {6'd0, if_b.match_cnt} !== e.c1) begin
        failures++;
        $display("FAIL sb_b cycle=%0d out=%b cnt=%0d expected out=%b cnt=%0d",
                 cycle, if_b.out, if_b.match_cnt, e.o[1], e.c1);
      end
      if (if_c.out !== e.o[2] || if_c.match_cnt !== e.c2) begin
        failures++;
        $display("FAIL sb_c cycle=%0d out=%b cnt=%0d expected out=%b cnt=%0d",
                 cycle, if_c.out, if_c.match_cnt, e.o[2], e.c2);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    checks += 3;
    if (if_a.out !== 1'b0 || if_a.match_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_a out=%b cnt=%0d expected 0/0", if_a.out, if_a.match_cnt);
    end
    if (if_b.out !== 1'b0 || if_b.match_cnt !== 2'd0) begin
      failures++;
      $display("FAIL reset_b out=%b cnt=%0d expected 0/0", if_b.out, if_b.match_cnt);
    end
    if (if_c.out !== 1'b0 || if_c.match_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_c out=%b cnt=%0d expected 0/0", if_c.out, if_c.match_cnt);
    end
  endtask

  task automatic test_basic();
    int base;
    load(0, 32'hB, 1'b0, 1'b0);
    base = pulses[0];
    send_bits(0, 32'b1011, 4);
    settle();
    checks += 2;
    if (pulses[0] - base !== 1) begin
      failures++;
      $display("FAIL basic_pulses got=%0d expected=1", pulses[0] - base);
    end
    if (if_a.match_cnt !== 8'd1) begin
      failures++;
      $display("FAIL basic_cnt got=%0d expected=1", if_a.match_cnt);
    end
  endtask

  task automatic test_overlap();
    int base;
    load(0, 32'hB, 1'b0, 1'b1);
    base = pulses[0];
    send_bits(0, 32'b1011011, 7);
    settle();
    checks++;
    if (pulses[0] - base !== 1) begin
      failures++;
      $display("FAIL nonovl_pulses got=%0d expected=1", pulses[0] - base);
    end
    load(0, 32'hB, 1'b1, 1'b1);
    base = pulses[0];
    send_bits(0, 32'b1011011, 7);
    settle();
    checks += 2;
    if (pulses[0] - base !== 2) begin
      failures++;
      $display("FAIL ovl_pulses got=%0d expected=2", pulses[0] - base);
    end
    if (if_a.match_cnt !== 8'd2) begin
      failures++;
      $display("FAIL ovl_cnt got=%0d expected=2", if_a.match_cnt);
    end
  endtask

  task automatic test_valid_gap();
    int base;
    load(0, 32'hB, 1'b0, 1'b0);
    base = pulses[0];
    send_bits(0, 32'b10, 2);
    for (int j = 0; j < 3; j++) step(0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    send_bits(0, 32'b11, 2);
    settle();
    checks++;
    if (pulses[0] - base !== 1) begin
      failures++;
      $display("FAIL gap_pulses got=%0d expected=1", pulses[0] - base);
    end
  endtask

  task automatic test_abort();
    int base;
    // Abandoned by cfg_load: 1,0,1 | load | 1 must not match.
    load(0, 32'hB, 1'b0, 1'b0);
    base = pulses[0];
    send_bits(0, 32'b101, 3);
    load(0, 32'hB, 1'b0, 1'b0);
    send_bits(0, 32'b1, 1);
    settle();
    checks++;
    if (pulses[0] - base !== 0) begin
      failures++;
      $display("FAIL abort_load_pulses got=%0d expected=0", pulses[0] - base);
    end
    base = pulses[0];
    send_bits(0, 32'b1011, 4);
    settle();
    checks++;
    if (pulses[0] - base !== 1) begin
      failures++;
      $display("FAIL abort_load_after got=%0d expected=1", pulses[0] - base);
    end
    // Abandoned by rst, then reconfigured.
    load(0, 32'hB, 1'b0, 1'b0);
    base = pulses[0];
    send_bits(0, 32'b101, 3);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    load(0, 32'hB, 1'b0, 1'b0);
    send_bits(0, 32'b1, 1);
    settle();
    checks++;
    if (pulses[0] - base !== 0) begin
      failures++;
      $display("FAIL abort_rst_pulses got=%0d expected=0", pulses[0] - base);
    end
    base = pulses[0];
    send_bits(0, 32'b1011, 4);
    settle();
    checks++;
    if (pulses[0] - base !== 1) begin
      failures++;
      $display("FAIL abort_rst_after got=%0d expected=1", pulses[0] - base);
    end
  endtask

  task automatic test_saturate();
    int base;
    load(1, 32'hF, 1'b1, 1'b1);
    base = pulses[1];
    send_bits(1, 32'hFF, 8);
    settle();
    checks += 2;
    if (pulses[1] - base !== 5) begin
      failures++;
      $display("FAIL sat_pulses got=%0d expected=5", pulses[1] - base);
    end
    if (if_b.match_cnt !== 2'd3) begin
      failures++;
      $display("FAIL sat_cnt got=%0d expected=3", if_b.match_cnt);
    end
    step(1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    #2;
    checks++;
    if (if_b.match_cnt !== 2'd1 || if_b.out !== 1'b1) begin
      failures++;
      $display("FAIL clr_with_match cnt=%0d out=%b expected cnt=1 out=1",
               if_b.match_cnt, if_b.out);
    end
  endtask

  task automatic test_random();
    int          base, mbase;
    logic [7:0]  pat;
    logic [199:0] bits;
    pat = 8'hA5;
    for (int mode = 0; mode < 2; mode++) begin
      int n = 0;
      while (n < 200) begin
        if (($urandom_range(0, 15) == 0) && (n + 8 <= 200)) begin
          for (int j = 7; j >= 0; j--) begin
            bits[n] = pat[j];
            n++;
          end
        end else begin
          bits[n] = 1'($urandom_range(0, 1));
          n++;
        end
      end
      load(2, 32'hA5, mode[0], 1'b1);
      base  = pulses[2];
      mbase = m_pulses[2];
      for (int j = 0; j < 200; j++) begin
        while ($urandom_range(0, 3) == 0) step(2, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(2, 1'b1, bits[j], 1'b0, 32'd0, 1'b0, 1'b0);
      end
      settle();
      checks++;
      if ((pulses[2] - base) !== (m_pulses[2] - mbase)) begin
        failures++;
        $display("FAIL random_mode%0d_pulses got=%0d expected=%0d",
                 mode, pulses[2] - base, m_pulses[2] - mbase);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_valid_gap();
    test_abort();
    test_saturate();
    test_random();
    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
